// File: rtl/ram_fifo_ctrl.sv
// Pointer/flag controller that pairs with an external 1-cycle-latency dual-port RAM to form a synchronous FIFO.
// Optional almost_full/almost_empty thresholds are built only when RAM_FIFO_ALMOST_FLAGS_EN is defined.
module ram_fifo_ctrl #(
  parameter int ram_width = 8,
  parameter int addr_size = 4,
  parameter int ram_depth = 16,
  parameter int AF_LEVEL  = 14,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [ram_width-1:0] wr_data,
  input  logic                 pop,
  output logic [ram_width-1:0] ram_data_in,
  output logic [addr_size-1:0] ram_wr_addr,
  output logic                 ram_write_en,
  output logic [addr_size-1:0] ram_rd_addr,
  output logic                 ram_read_en,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic [addr_size:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam logic [addr_size:0]   DEPTH_C = (addr_size + 1)'(ram_depth);
  localparam logic [addr_size:0]   CNT_ONE = (addr_size + 1)'(1);
  localparam logic [addr_size-1:0] PTR_ONE = addr_size'(1);

  // Pointers wrap by natural overflow, so the depth must be a power of two.
  if (ram_depth != (1 << addr_size)) begin : g_bad_depth
    $error("ram_fifo_ctrl: ram_depth must equal 2**addr_size");
  end
  if ((AF_LEVEL > ram_depth) || (AE_LEVEL < 0)) begin : g_bad_levels
    $error("ram_fifo_ctrl: almost thresholds out of range");
  end

  logic [addr_size-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_size-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_size:0]   count_q, count_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 full_w, empty_w;
  logic                 push_ok, pop_ok;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Reset blocks both RAM ports in the same cycle it is asserted.
  assign push_ok = push & ~full_w & ~reset;
  assign pop_ok  = pop & ~empty_w & ~reset;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = pop_ok;
    overflow_d  = push & full_w;
    underflow_d = pop & empty_w;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_data_in  = wr_data;
  assign ram_wr_addr  = wr_ptr_q;
  assign ram_write_en = push_ok;
  assign ram_rd_addr  = rd_ptr_q;
  assign ram_read_en  = pop_ok;
  // A read issued just before reset must not surface while reset is held.
  assign rd_valid     = rd_valid_q & ~reset;
  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [addr_size:0] AF_C = (addr_size + 1)'(AF_LEVEL);
  localparam logic [addr_size:0] AE_C = (addr_size + 1)'(AE_LEVEL);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model drive and check every cycle.
module tb_ram_fifo_ctrl;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  ram_data_in;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic          ram_write_en, ram_read_en, rd_valid, full, empty;
  logic [AW:0]   count;
  logic          overflow, underflow, almost_full, almost_empty;

  ram_fifo_ctrl #(.ram_width(W), .addr_size(AW), .ram_depth(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .wr_data(wr_data), .pop(pop),
    .ram_data_in(ram_data_in), .ram_wr_addr(ram_wr_addr), .ram_write_en(ram_write_en),
    .ram_rd_addr(ram_rd_addr), .ram_read_en(ram_read_en), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_read_en)  ram_q <= mem[ram_rd_addr];
  end

  // ---------------- scoreboard / model ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int wr_total = 0, rd_total = 0;
  logic e_rv_q = 1'b0, e_ovf_q = 1'b0, e_unf_q = 1'b0;
  logic [W-1:0] e_rdata_q = '0;

  logic          s_wen, s_ren, s_rv, s_full, s_empty, s_ovf, s_unf, s_af, s_ae;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [AW:0]   s_count;
  logic [W-1:0]  s_din, s_rdata;
  logic          e_wen, e_ren, e_rv, e_full, e_empty, e_ovf, e_unf, e_af, e_ae;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [AW:0]   e_count;
  logic [W-1:0]  e_rdata;

  // One clock cycle: apply inputs just after the edge, sample at the falling edge, advance model.
  task automatic cycle(input logic r, input logic p, input logic o, input logic [W-1:0] d);
    int sz;
    reset = r; push = p; pop = o; wr_data = d;
    @(negedge clk);
    s_wen = ram_write_en; s_waddr = ram_wr_addr; s_ren = ram_read_en; s_raddr = ram_rd_addr;
    s_din = ram_data_in; s_rv = rd_valid; s_full = full; s_empty = empty; s_count = count;
    s_ovf = overflow; s_unf = underflow; s_af = almost_full; s_ae = almost_empty; s_rdata = ram_q;
    sz = exp_q.size();
    e_wen   = !r && p && (sz < DEPTH);
    e_ren   = !r && o && (sz > 0);
    e_waddr = AW'(wr_total % DEPTH);
    e_raddr = AW'(rd_total % DEPTH);
    e_count = (AW+1)'(sz);
    e_full  = (sz == DEPTH);
    e_empty = (sz == 0);
    e_rv    = e_rv_q && !r;
    e_ovf   = e_ovf_q;
    e_unf   = e_unf_q;
    e_rdata = e_rdata_q;
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    e_af = (sz >= AF);
    e_ae = (sz <= AE);
`else
    e_af = 1'b0;
    e_ae = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      wr_total = 0; rd_total = 0;
      e_rv_q = 1'b0; e_ovf_q = 1'b0; e_unf_q = 1'b0;
    end else begin
      e_ovf_q = p && (sz == DEPTH);
      e_unf_q = o && (sz == 0);
      e_rv_q  = e_ren;
      if (e_ren) begin
        e_rdata_q = exp_q.pop_front();
        rd_total++;
      end
      if (e_wen) begin
        exp_q.push_back(d);
        wr_total++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 8'h3c);
    tests++; if (s_wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b exp 0", s_wen); end
    tests++; if (s_ren !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b exp 0", s_ren); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_count !== '0) begin fails++; $display("FAIL reset_count: got %0d exp 0", s_count); end
    tests++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin fails++; $display("FAIL reset_flags: empty %b full %b exp 1 0", s_empty, s_full); end
    tests++; if (s_rv !== 1'b0 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin fails++; $display("FAIL reset_pulses: rv %b ovf %b unf %b exp 0 0 0", s_rv, s_ovf, s_unf); end
    tests++; if (s_af !== e_af || s_ae !== e_ae) begin fails++; $display("FAIL reset_almost: af %b ae %b exp %b %b", s_af, s_ae, e_af, e_ae); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, W'(i + 1));
      tests++; if (s_wen !== 1'b1 || s_waddr !== AW'(i)) begin fails++; $display("FAIL fill_write[%0d]: wen %b addr %0d exp 1 %0d", i, s_wen, s_waddr, i); end
      tests++; if (s_din !== W'(i + 1)) begin fails++; $display("FAIL fill_din[%0d]: got %0h exp %0h", i, s_din, i + 1); end
      tests++; if (s_empty !== (i == 0)) begin fails++; $display("FAIL fill_empty[%0d]: got %b exp %b", i, s_empty, i == 0); end
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_count !== 5'd16 || s_full !== 1'b1) begin fails++; $display("FAIL fill_full: count %0d full %b exp 16 1", s_count, s_full); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 1'b1, 1'b0, 8'haa);
    tests++; if (s_wen !== 1'b0) begin fails++; $display("FAIL ovf_wen: got %b exp 0", s_wen); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_ovf !== 1'b1 || s_count !== 5'd16) begin fails++; $display("FAIL ovf_pulse: ovf %b count %0d exp 1 16", s_ovf, s_count); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_ovf !== 1'b0) begin fails++; $display("FAIL ovf_single: got %b exp 0", s_ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b0, i < DEPTH, 8'h00);
      if (i < DEPTH) begin
        tests++; if (s_ren !== 1'b1 || s_raddr !== AW'(i)) begin fails++; $display("FAIL drain_read[%0d]: ren %b addr %0d exp 1 %0d", i, s_ren, s_raddr, i); end
      end
      if (i > 0) begin
        tests++; if (s_rv !== 1'b1 || s_rdata !== W'(i)) begin fails++; $display("FAIL drain_data[%0d]: rv %b data %0h exp 1 %0h", i, s_rv, s_rdata, i); end
      end
    end
    tests++; if (s_empty !== 1'b1 || s_count !== '0) begin fails++; $display("FAIL drain_empty: empty %b count %0d exp 1 0", s_empty, s_count); end
  endtask

  task automatic test_simul_empty();
    cycle(1'b0, 1'b1, 1'b1, 8'h55);
    tests++; if (s_wen !== 1'b1 || s_ren !== 1'b0) begin fails++; $display("FAIL simul_en: wen %b ren %b exp 1 0", s_wen, s_ren); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    tests++; if (s_unf !== 1'b1 || s_count !== 5'd1) begin fails++; $display("FAIL simul_unf: unf %b count %0d exp 1 1", s_unf, s_count); end
    tests++; if (s_ren !== 1'b1 || s_rv !== 1'b0) begin fails++; $display("FAIL simul_pop: ren %b rv %b exp 1 0", s_ren, s_rv); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_rv !== 1'b1 || s_rdata !== 8'h55 || s_unf !== 1'b0) begin fails++; $display("FAIL simul_data: rv %b data %0h unf %b exp 1 55 0", s_rv, s_rdata, s_unf); end
  endtask

  task automatic test_wrap_and_reset();
    logic [W-1:0] d;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, W'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom_range(0, 255));
      cycle(1'b0, 1'b1, 1'b1, d);
      tests++; if (s_count !== 5'd3 || s_wen !== 1'b1 || s_ren !== 1'b1) begin fails++; $display("FAIL wrap_steady[%0d]: count %0d wen %b ren %b exp 3 1 1", i, s_count, s_wen, s_ren); end
      tests++; if (s_waddr !== e_waddr || s_raddr !== e_raddr) begin fails++; $display("FAIL wrap_addr[%0d]: wa %0d ra %0d exp %0d %0d", i, s_waddr, s_raddr, e_waddr, e_raddr); end
      if (i > 0) begin
        tests++; if (s_rv !== 1'b1 || s_rdata !== e_rdata) begin fails++; $display("FAIL wrap_data[%0d]: rv %b data %0h exp 1 %0h", i, s_rv, s_rdata, e_rdata); end
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    tests++; if (s_ren !== 1'b1) begin fails++; $display("FAIL rstmid_pop: ren %b exp 1", s_ren); end
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if (s_rv !== 1'b0) begin fails++; $display("FAIL rstmid_rv: got %b exp 0", s_rv); end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_rv !== 1'b0 || s_count !== '0 || s_empty !== 1'b1) begin fails++; $display("FAIL rstmid_state: rv %b count %0d empty %b exp 0 0 1", s_rv, s_count, s_empty); end
  endtask

  task automatic test_almost();
    for (int i = 0; i < AF - 1; i++) cycle(1'b0, 1'b1, 1'b0, W'(i));
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_count !== 5'd13 || s_af !== 1'b0) begin fails++; $display("FAIL almost_13: count %0d af %b exp 13 0", s_count, s_af); end
    cycle(1'b0, 1'b1, 1'b0, 8'h0d);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    tests++; if (s_af !== 1'b1 || s_ae !== 1'b0) begin fails++; $display("FAIL almost_full: af %b ae %b exp 1 0", s_af, s_ae); end
`else
    tests++; if (s_af !== 1'b0 || s_ae !== 1'b0) begin fails++; $display("FAIL almost_tied_hi: af %b ae %b exp 0 0", s_af, s_ae); end
`endif
    for (int i = 0; i < AF - AE; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (s_count !== 5'd2) begin fails++; $display("FAIL almost_2_count: got %0d exp 2", s_count); end
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    tests++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin fails++; $display("FAIL almost_empty: ae %b af %b exp 1 0", s_ae, s_af); end
`else
    tests++; if (s_af !== 1'b0 || s_ae !== 1'b0) begin fails++; $display("FAIL almost_tied_lo: af %b ae %b exp 0 0", s_af, s_ae); end
`endif
  endtask

  task automatic test_random();
    int pp, po;
    for (int i = 0; i < 400; i++) begin
      case ((i / 50) % 3)
        0:       begin pp = 80; po = 30; end
        1:       begin pp = 25; po = 80; end
        default: begin pp = 55; po = 55; end
      endcase
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < po),
            W'($urandom_range(0, 255)));
      tests++; if (s_wen !== e_wen || s_waddr !== e_waddr || s_din !== wr_data) begin fails++; $display("FAIL rnd_write[%0d]: wen %b addr %0d din %0h exp %b %0d %0h", i, s_wen, s_waddr, s_din, e_wen, e_waddr, wr_data); end
      tests++; if (s_ren !== e_ren || s_raddr !== e_raddr) begin fails++; $display("FAIL rnd_read[%0d]: ren %b addr %0d exp %b %0d", i, s_ren, s_raddr, e_ren, e_raddr); end
      tests++; if (s_count !== e_count || s_full !== e_full || s_empty !== e_empty) begin fails++; $display("FAIL rnd_occ[%0d]: count %0d full %b empty %b exp %0d %b %b", i, s_count, s_full, s_empty, e_count, e_full, e_empty); end
      tests++; if (s_ovf !== e_ovf || s_unf !== e_unf) begin fails++; $display("FAIL rnd_pulse[%0d]: ovf %b unf %b exp %b %b", i, s_ovf, s_unf, e_ovf, e_unf); end
      tests++; if (s_rv !== e_rv) begin fails++; $display("FAIL rnd_rv[%0d]: got %b exp %b", i, s_rv, e_rv); end
      if (e_rv) begin
        tests++; if (s_rdata !== e_rdata) begin fails++; $display("FAIL rnd_data[%0d]: got %0h exp %0h", i, s_rdata, e_rdata); end
      end
      tests++; if (s_af !== e_af || s_ae !== e_ae) begin fails++; $display("FAIL rnd_almost[%0d]: af %b ae %b exp %b %b", i, s_af, s_ae, e_af, e_ae); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simul_empty();
    test_wrap_and_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    test_almost();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
